// File: rtl/div_issue_ctrl.sv
// Issue/commit sequencer for the execute-stage divider IPs (AXI-stream operand and result channels).
// Optional macro DIV_ZERO_BYPASS_EN: a zero divisor completes locally without using the IP.
module div_issue_ctrl #(
  parameter int WIDTH       = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int LAT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               es_valid,
  input  logic               op_div,
  input  logic               op_divu,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               flush,
  input  logic               ms_allowin,
  output logic               div_signed,
  output logic               dividend_tvalid,
  input  logic               dividend_tready,
  output logic               divisor_tvalid,
  input  logic               divisor_tready,
  output logic [WIDTH-1:0]   dividend_tdata,
  output logic [WIDTH-1:0]   divisor_tdata,
  input  logic               dout_tvalid,
  input  logic [2*WIDTH-1:0] dout_tdata,
  output logic               ready_go,
  output logic               hilo_we,
  output logic [WIDTH-1:0]   lo_wdata,
  output logic [WIDTH-1:0]   hi_wdata,
  output logic [LAT_W-1:0]   div_lat,
  output logic               timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);
  localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4,
    S_ZERO  = 3'd5
  } state_t;

  state_t           state_r, state_nxt_s;
  logic             dvd_sent_r, dvs_sent_r;
  logic [LAT_W-1:0] lat_cnt_r, lat_inc_s;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             is_div_s, launch_s, zero_div_s, commit_s, tmo_active_s;
  logic             dvd_done_s, dvs_done_s;

  assign is_div_s     = es_valid & (op_div | op_divu);
  assign launch_s     = (state_r == S_IDLE) & is_div_s & ~flush;
  assign dvd_done_s   = dvd_sent_r | (dividend_tvalid & dividend_tready);
  assign dvs_done_s   = dvs_sent_r | (divisor_tvalid & divisor_tready);
  assign commit_s     = ((state_r == S_WAIT) & dout_tvalid & ~flush) | ((state_r == S_ZERO) & ~flush);
  assign tmo_active_s = (state_r == S_SEND) | (state_r == S_WAIT) | (state_r == S_DRAIN);
  assign lat_inc_s    = (lat_cnt_r == {LAT_W{1'b1}}) ? lat_cnt_r : lat_cnt_r + LAT_ONE;

`ifdef DIV_ZERO_BYPASS_EN
  assign zero_div_s = (src_b == {WIDTH{1'b0}});
`else
  assign zero_div_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic; a flush only cancels cleanly once no operand has reached the IP
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (launch_s) state_nxt_s = zero_div_s ? S_ZERO : S_SEND;
        else          state_nxt_s = S_IDLE;
      end
      S_SEND: begin
        if (flush)                          state_nxt_s = (dvd_done_s | dvs_done_s) ? S_DRAIN : S_IDLE;
        else if (dvd_done_s & dvs_done_s)   state_nxt_s = S_WAIT;
        else                                state_nxt_s = S_SEND;
      end
      S_WAIT: begin
        if (flush)            state_nxt_s = dout_tvalid ? S_IDLE : S_DRAIN;
        else if (dout_tvalid) state_nxt_s = ms_allowin ? S_IDLE : S_HOLD;
        else                  state_nxt_s = S_WAIT;
      end
      S_HOLD: begin
        if (ms_allowin | flush) state_nxt_s = S_IDLE;
        else                    state_nxt_s = S_HOLD;
      end
      S_DRAIN: begin
        if (dout_tvalid) state_nxt_s = S_IDLE;
        else             state_nxt_s = S_DRAIN;
      end
      S_ZERO: begin
        if (flush | ms_allowin) state_nxt_s = S_IDLE;
        else                    state_nxt_s = S_HOLD;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output logic: channel valids, stage handshake and HI/LO write port
  always_comb begin
    dividend_tvalid = 1'b0;
    divisor_tvalid  = 1'b0;
    ready_go        = 1'b1;
    hilo_we         = commit_s;
    lo_wdata        = {WIDTH{1'b0}};
    hi_wdata        = {WIDTH{1'b0}};
    if ((state_r == S_SEND) | (state_r == S_DRAIN)) begin
      dividend_tvalid = ~dvd_sent_r;
      divisor_tvalid  = ~dvs_sent_r;
    end else begin
      dividend_tvalid = 1'b0;
      divisor_tvalid  = 1'b0;
    end
    if (is_div_s) begin
      case (state_r)
        S_WAIT, S_ZERO: ready_go = commit_s;
        S_HOLD:         ready_go = 1'b1;
        default:        ready_go = 1'b0;
      endcase
    end else begin
      ready_go = 1'b1;
    end
    if (commit_s) begin
      if (state_r == S_ZERO) begin
        lo_wdata = {WIDTH{1'b1}};
        hi_wdata = dividend_tdata;
      end else begin
        lo_wdata = dout_tdata[2*WIDTH-1:WIDTH];
        hi_wdata = dout_tdata[WIDTH-1:0];
      end
    end else begin
      lo_wdata = {WIDTH{1'b0}};
      hi_wdata = {WIDTH{1'b0}};
    end
  end

  // Operand latch and per-channel sent flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dividend_tdata <= {WIDTH{1'b0}};
      divisor_tdata  <= {WIDTH{1'b0}};
      div_signed     <= 1'b0;
      dvd_sent_r     <= 1'b0;
      dvs_sent_r     <= 1'b0;
    end else if (launch_s) begin
      dividend_tdata <= src_a;
      divisor_tdata  <= src_b;
      div_signed     <= op_div;
      dvd_sent_r     <= 1'b0;
      dvs_sent_r     <= 1'b0;
    end else if ((state_r == S_SEND) | (state_r == S_DRAIN)) begin
      dvd_sent_r     <= dvd_done_s;
      dvs_sent_r     <= dvs_done_s;
    end else begin
      dvd_sent_r     <= dvd_sent_r;
      dvs_sent_r     <= dvs_sent_r;
    end
  end

  // Launch-to-result latency; the reported value includes the result cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt_r <= {LAT_W{1'b0}};
      div_lat   <= {LAT_W{1'b0}};
    end else begin
      if (launch_s)                                    lat_cnt_r <= {LAT_W{1'b0}};
      else if ((state_r == S_SEND) | (state_r == S_WAIT)) lat_cnt_r <= lat_inc_s;
      else                                             lat_cnt_r <= lat_cnt_r;
      if (commit_s) div_lat <= (state_r == S_ZERO) ? LAT_ONE : lat_inc_s;
      else          div_lat <= div_lat;
    end
  end

  // Watchdog on time spent waiting for the IP; the error flag is sticky
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_r   <= {TMO_W{1'b0}};
      timeout_err <= 1'b0;
    end else if (tmo_active_s) begin
      if (tmo_cnt_r != TMO_MAX) tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
      else                      tmo_cnt_r <= tmo_cnt_r;
      if (tmo_cnt_r == TMO_MAX - {{(TMO_W-1){1'b0}}, 1'b1}) timeout_err <= 1'b1;
      else                                                  timeout_err <= timeout_err;
    end else begin
      tmo_cnt_r   <= {TMO_W{1'b0}};
      timeout_err <= timeout_err;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed self-checking bench for div_issue_ctrl; the divider IP is played by hand-timed stimulus.
// Covers the DIV_ZERO_BYPASS_EN build and the default build.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        es_valid = 1'b0, op_div = 1'b0, op_divu = 1'b0;
  logic [31:0] src_a = 32'd0, src_b = 32'd0;
  logic        flush = 1'b0, ms_allowin = 1'b1;
  logic        div_signed, dividend_tvalid, divisor_tvalid;
  logic        dividend_tready = 1'b1, divisor_tready = 1'b1;
  logic [31:0] dividend_tdata, divisor_tdata;
  logic        dout_tvalid = 1'b0;
  logic [63:0] dout_tdata = 64'd0;
  logic        ready_go, hilo_we, timeout_err;
  logic [31:0] lo_wdata, hi_wdata;
  logic [7:0]  div_lat;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt = 0, dvd_hs_cnt = 0, dvs_hs_cnt = 0;
  int we_base, dvd_base, dvs_base;

  div_issue_ctrl #(.WIDTH(32), .TIMEOUT_CYC(16), .LAT_W(8)) dut (
    .clk(clk), .reset(reset), .es_valid(es_valid), .op_div(op_div), .op_divu(op_divu),
    .src_a(src_a), .src_b(src_b), .flush(flush), .ms_allowin(ms_allowin),
    .div_signed(div_signed), .dividend_tvalid(dividend_tvalid), .dividend_tready(dividend_tready),
    .divisor_tvalid(divisor_tvalid), .divisor_tready(divisor_tready),
    .dividend_tdata(dividend_tdata), .divisor_tdata(divisor_tdata),
    .dout_tvalid(dout_tvalid), .dout_tdata(dout_tdata), .ready_go(ready_go),
    .hilo_we(hilo_we), .lo_wdata(lo_wdata), .hi_wdata(hi_wdata),
    .div_lat(div_lat), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Count write strobes and accepted operand beats
  always @(posedge clk) begin
    if (hilo_we) we_cnt <= we_cnt + 1;
    if (dividend_tvalid && dividend_tready) dvd_hs_cnt <= dvd_hs_cnt + 1;
    if (divisor_tvalid && divisor_tready) dvs_hs_cnt <= dvs_hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    es_valid = 1'b1;
    op_div   = sgn;
    op_divu  = ~sgn;
    src_a    = a;
    src_b    = b;
  endtask

  task automatic retire();
    es_valid    = 1'b0;
    op_div      = 1'b0;
    op_divu     = 1'b0;
    dout_tvalid = 1'b0;
  endtask

  task automatic snap();
    we_base  = we_cnt;
    dvd_base = dvd_hs_cnt;
    dvs_base = dvs_hs_cnt;
  endtask

  initial begin
    // Reset values
    step(); step(); mid();
    check("rst_ready_go", ready_go, 1);
    check("rst_tvalid", {dividend_tvalid, divisor_tvalid}, 0);
    check("rst_we", hilo_we, 0);
    check("rst_lat", div_lat, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_tdata", {dividend_tdata, divisor_tdata}, 0);
    check("rst_wdata", {lo_wdata, hi_wdata}, 0);
    step(); reset = 1'b0;

    // divu 100/7, result 10 cycles after the handshake cycle
    snap();
    step(); issue(1'b0, 32'd100, 32'd7); mid();
    check("t1_idle_rg", ready_go, 0);
    check("t1_idle_tv", dividend_tvalid, 0);
    step(); src_a = 32'hDEAD_BEEF; mid();
    check("t1_send_tv", {dividend_tvalid, divisor_tvalid}, 2'b11);
    check("t1_tdata", {dividend_tdata, divisor_tdata}, {32'd100, 32'd7});
    check("t1_signed", div_signed, 0);
    step(); mid();
    check("t1_tv_once", {dividend_tvalid, divisor_tvalid}, 2'b00);
    repeat (8) step();
    step(); dout_tvalid = 1'b1; dout_tdata = {32'd14, 32'd2}; mid();
    check("t1_we", hilo_we, 1);
    check("t1_lohi", {lo_wdata, hi_wdata}, {32'd14, 32'd2});
    check("t1_rg", ready_go, 1);
    step(); retire(); mid();
    check("t1_we_off", hilo_we, 0);
    check("t1_lat", div_lat, 11);
    check("t1_we_cnt", we_cnt - we_base, 1);
    check("t1_hs_cnt", {dvd_hs_cnt - dvd_base, dvs_hs_cnt - dvs_base}, {32'd1, 32'd1});

    // signed div 0xFFFFFFF9/2
    step(); issue(1'b1, 32'hFFFF_FFF9, 32'd2); mid();
    step(); mid();
    check("t2_signed", div_signed, 1);
    step();
    step(); dout_tvalid = 1'b1; dout_tdata = {32'hFFFF_FFFD, 32'hFFFF_FFFF}; mid();
    check("t2_lohi", {lo_wdata, hi_wdata}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    check("t2_we", hilo_we, 1);
    step(); retire(); mid();
    check("t2_lat", div_lat, 3);

    // dividend channel stalls 3 cycles
    snap();
    step(); issue(1'b0, 32'd50, 32'd5); dividend_tready = 1'b0; mid();
    step(); mid();
    check("t3_c1_tv", {dividend_tvalid, divisor_tvalid}, 2'b11);
    step(); mid();
    check("t3_c2_tv", {dividend_tvalid, divisor_tvalid}, 2'b10);
    step();
    step(); dividend_tready = 1'b1; mid();
    check("t3_c4_tv", {dividend_tvalid, divisor_tvalid}, 2'b10);
    step(); mid();
    check("t3_wait_tv", {dividend_tvalid, divisor_tvalid}, 2'b00);
    step(); dout_tvalid = 1'b1; dout_tdata = {32'd10, 32'd0}; mid();
    check("t3_lohi", {hilo_we, lo_wdata, hi_wdata}, {1'b1, 32'd10, 32'd0});
    step(); retire(); mid();
    check("t3_hs_cnt", {dvd_hs_cnt - dvd_base, dvs_hs_cnt - dvs_base}, {32'd1, 32'd1});
    check("t3_lat", div_lat, 6);

    // result while memory stage is blocked
    snap();
    step(); issue(1'b0, 32'd20, 32'd6); ms_allowin = 1'b0; mid();
    step();
    step();
    step(); dout_tvalid = 1'b1; dout_tdata = {32'd3, 32'd2}; mid();
    check("t4_we", {hilo_we, ready_go}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step(); dout_tvalid = (i == 1); mid();
      check("t4_hold_rg", ready_go, 1);
      check("t4_hold_we", hilo_we, 0);
    end
    step(); dout_tvalid = 1'b0; ms_allowin = 1'b1; mid();
    check("t4_exit_rg", ready_go, 1);
    step(); retire(); mid();
    check("t4_we_cnt", we_cnt - we_base, 1);

    // flush in WAIT, then a new divu 9/3 waits for the stale result
    snap();
    step(); issue(1'b0, 32'd40, 32'd7); mid();
    step();
    step(); flush = 1'b1; mid();
    check("t5_flush_we", hilo_we, 0);
    step(); flush = 1'b0; issue(1'b0, 32'd9, 32'd3); mid();
    check("t5_drain_rg", ready_go, 0);
    check("t5_drain_tv", dividend_tvalid, 0);
    step(); mid();
    check("t5_drain_rg2", ready_go, 0);
    step(); dout_tvalid = 1'b1; dout_tdata = {32'd5, 32'd5}; mid();
    check("t5_stale_we", hilo_we, 0);
    check("t5_stale_rg", ready_go, 0);
    step(); dout_tvalid = 1'b0; mid();
    check("t5_idle_tv", dividend_tvalid, 0);
    step(); mid();
    check("t5_send_tv", dividend_tvalid, 1);
    check("t5_tdata", dividend_tdata, 32'd9);
    step();
    step(); dout_tvalid = 1'b1; dout_tdata = {32'd3, 32'd0}; mid();
    check("t5_lohi", {hilo_we, lo_wdata, hi_wdata}, {1'b1, 32'd3, 32'd0});
    step(); retire(); mid();
    check("t5_we_cnt", we_cnt - we_base, 1);

    // flush in SEND before any operand is taken returns straight to IDLE
    step(); issue(1'b0, 32'd8, 32'd2); dividend_tready = 1'b0; divisor_tready = 1'b0; mid();
    step(); flush = 1'b1; mid();
    step(); flush = 1'b0; retire(); mid();
    check("t6_idle_tv", {dividend_tvalid, divisor_tvalid}, 2'b00);
    dividend_tready = 1'b1; divisor_tready = 1'b1;

    // async reset mid-operation
    step(); issue(1'b0, 32'd7, 32'd7); dividend_tready = 1'b0; mid();
    step(); mid();
    reset = 1'b1; #1;
    check("t7_rst_tv", dividend_tvalid, 0);
    check("t7_rst_lat", div_lat, 0);
    step(); reset = 1'b0; retire(); dividend_tready = 1'b1; mid();

    // watchdog: IP never accepts
    step(); issue(1'b0, 32'd1, 32'd1); dividend_tready = 1'b0; divisor_tready = 1'b0; mid();
    step();
    repeat (15) step();
    mid();
    check("t8_tmo_early", timeout_err, 0);
    step(); flush = 1'b1; es_valid = 1'b0; mid();
    check("t8_tmo_set", timeout_err, 1);
    step(); flush = 1'b0; retire(); mid();
    check("t8_tmo_sticky", timeout_err, 1);
    check("t8_idle_tv", dividend_tvalid, 0);
    dividend_tready = 1'b1; divisor_tready = 1'b1;

    // divide by zero
`ifdef DIV_ZERO_BYPASS_EN
    snap();
    step(); issue(1'b0, 32'd5, 32'd0); mid();
    step(); mid();
    check("t9_no_tv", {dividend_tvalid, divisor_tvalid}, 2'b00);
    check("t9_lohi", {hilo_we, lo_wdata, hi_wdata}, {1'b1, 32'hFFFF_FFFF, 32'd5});
    check("t9_rg", ready_go, 1);
    step(); retire(); mid();
    check("t9_lat", div_lat, 1);
    check("t9_hs_cnt", {dvd_hs_cnt - dvd_base, dvs_hs_cnt - dvs_base}, {32'd0, 32'd0});
`else
    step(); issue(1'b0, 32'd5, 32'd0); mid();
    step(); mid();
    check("t9_tv", {dividend_tvalid, divisor_tvalid}, 2'b11);
    check("t9_tdata", divisor_tdata, 32'd0);
    step(); dout_tvalid = 1'b1; dout_tdata = {32'hFFFF_FFFF, 32'd5}; mid();
    check("t9_lohi", {hilo_we, lo_wdata, hi_wdata}, {1'b1, 32'hFFFF_FFFF, 32'd5});
    step(); retire(); mid();
    check("t9_lat", div_lat, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequencer for the execute-stage divider IPs (signed and unsigned, AXI-stream operand/result channels).
- Launches each div/divu exactly once and latches its operands.
- Produces the stage ready_go and one-cycle HI/LO write strobes.
- Absorbs exception/eret flushes by draining the non-abortable IP before the next divide may launch.

Parameters:
- WIDTH, 32, operand width; result bus is 2*WIDTH.
- TIMEOUT_CYC, 64, cycles in SEND/WAIT/DRAIN before the sticky timeout flag is set.
- LAT_W, 8, width of the saturating latency counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- es_valid  in  1  execute stage holds a valid instruction
- op_div  in  1  current instruction is div (signed)
- op_divu  in  1  current instruction is divu
- src_a  in  WIDTH  dividend (rs value)
- src_b  in  WIDTH  divisor (rt value)
- flush  in  1  ws_ex or eret_flush; cancels the current instruction
- ms_allowin  in  1  memory stage accepts
- div_signed  out  1  selects the signed IP channel set; latched at launch
- dividend_tvalid  out  1  dividend channel valid
- dividend_tready  in  1  dividend channel ready
- divisor_tvalid  out  1  divisor channel valid
- divisor_tready  in  1  divisor channel ready
- dividend_tdata  out  WIDTH  latched dividend
- divisor_tdata  out  WIDTH  latched divisor
- dout_tvalid  in  1  result valid (single-cycle pulse)
- dout_tdata  in  2*WIDTH  {quotient, remainder}
- ready_go  out  1  stage may advance
- hilo_we  out  1  one-cycle HI/LO write strobe
- lo_wdata  out  WIDTH  quotient, dout_tdata[2W-1:W]
- hi_wdata  out  WIDTH  remainder, dout_tdata[W-1:0]
- div_lat  out  LAT_W  cycles from launch to result of the last completed divide; saturates at all-ones
- timeout_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset (async): state=IDLE; all tvalid=0; hilo_we=0; div_lat=0; timeout_err=0; sent flags=0; data outputs=0.
- is_div = es_valid & (op_div|op_divu). ready_go=1 whenever !is_div; otherwise ready_go is defined per state below.
- IDLE:
  - If is_div & !flush: latch src_a, src_b, div_signed=op_div; clear sent flags; go to SEND. ready_go=0.
  - If flush: stay in IDLE.
- SEND:
  - dividend_tvalid = !dvd_sent; divisor_tvalid = !dvs_sent.
  - Each sent flag is set on its own handshake; the two may complete in the same or different cycles.
  - When both handshakes are complete (counting this cycle), go to WAIT.
  - Flush with neither operand accepted: go to IDLE.
  - Flush with either operand accepted: go to DRAIN.
- WAIT:
  - On dout_tvalid & !flush: hilo_we=1 for exactly this cycle; ready_go=1; capture div_lat.
  - Then go to IDLE if ms_allowin, else HOLD.
  - On flush: go to DRAIN with no write. If flush and dout_tvalid coincide, discard the result and go to IDLE.
- HOLD:
  - ready_go=1; hilo_we=0, so there is no second write.
  - Go to IDLE on ms_allowin or flush.
- DRAIN:
  - Finish sending any unsent operand.
  - On dout_tvalid: discard the result (hilo_we=0) and go to IDLE.
  - ready_go=0 for any divide present in the stage.
  - A new divide arriving during DRAIN launches only after the controller returns to IDLE.
- Latency counter:
  - Cleared on IDLE->SEND; increments each cycle in SEND/WAIT; saturates.
  - div_lat updates only on a committed result.
- Timeout: a separate counter runs in SEND/WAIT/DRAIN and clears in IDLE/HOLD. Reaching TIMEOUT_CYC sets timeout_err. This does not alter state flow.
- Operands and div_signed are stable from launch until return to IDLE; src_a/src_b changes after launch are ignored.
- dout_tvalid in IDLE or HOLD is ignored.
- Reset mid-operation returns to IDLE immediately. The IP is reset by the same reset.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined: a divisor of 0 at launch skips the IP. The controller goes directly to a completion cycle with hilo_we=1, lo_wdata=all-ones, hi_wdata=src_a, ready_go=1, div_lat=1; it then follows the WAIT exit rules. No tvalid is raised.
- Undefined: divide-by-zero is sent to the IP like any other divide.

Test Plan:
- divu 100/7, IP latency 10, ms_allowin=1 -> both tvalid high one cycle; hilo_we pulse once with LO=14, HI=2; div_lat=11.
- div 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, div_signed=1.
- dividend_tready low 3 cycles while divisor_tready=1 -> divisor sent once, dividend sent in cycle 4, no duplicate handshake; result correct.
- Result arrives while ms_allowin=0 for 4 cycles -> HOLD with ready_go=1 throughout; exactly one hilo_we.
- Flush in WAIT, then new divu 9/3 enters the stage -> ready_go=0 until the stale dout_tvalid is discarded (no we); new divide then yields LO=3, HI=0.
- With DIV_ZERO_BYPASS_EN: divu 5/0 -> no tvalid; LO=0xFFFFFFFF, HI=5, next cycle. With TIMEOUT_CYC=16 and no dout_tvalid -> timeout_err=1 after 16 cycles.
